fp_divider: RTL and testbench

- Iterative IEEE-754 single-precision divider, quotient = a / b. It is the inverse-operation companion to the team's combinational floating-point multiplier.
- Uses restoring division of the 24-bit significands, one quotient bit per clock, behind a start/busy/valid handshake.
- Sits beside the multiplier in the arithmetic datapath.
- Same numeric conventions as the multiplier:
  - Zero is exp==0 and mantissa==0.
  - Every other operand gets a hidden 1.
  - No denormal, Inf or NaN input handling.
  - Results are truncated, not rounded.

---
 rtl/fp_divider.sv | 168 ++++++++++++++++
 tb/tb_fp_divider.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/fp_divider.sv
// Iterative single-precision divider: restoring division of the
// significands, one quotient bit per clock, start/busy/valid handshake.
module fp_divider #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int BIAS  = 127
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [EXP_W+MAN_W:0]   a,
  input  logic [EXP_W+MAN_W:0]   b,
  output logic                   busy,
  output logic                   valid,
  output logic [EXP_W+MAN_W:0]   quotient,
  output logic                   div_by_zero
);

  localparam int DW = 1 + EXP_W + MAN_W;
  localparam int SW = MAN_W + 1;
  localparam int RW = SW + 1;
  localparam int CW = $clog2(RW);
  localparam int EW = EXP_W + 2;

  localparam logic [CW-1:0]   CNT_LAST = CW'(RW - 1);
  localparam logic [EW-2:0]   EXP_MAX  = (EW-1)'((2 ** EXP_W) - 1);
  localparam logic [EW-1:0]   BIAS_E   = EW'(BIAS);
  localparam logic [EXP_W-1:0] EXP_ONES = '1;

  typedef enum logic [1:0] {
    IDLE,
    DIV,
    NORM,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [RW-1:0]    r_q, r_d;
  logic [RW-1:0]    q_q, q_d;
  logic [SW-1:0]    sb_q, sb_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [EXP_W-1:0] ea_q, ea_d;
  logic [EXP_W-1:0] eb_q, eb_d;
  logic             sign_q, sign_d;
  logic [DW-1:0]    quot_q, quot_d;
  logic             dbz_q, dbz_d;

  logic             a_zero, b_zero, in_sign;
  logic [RW-1:0]    sb_ext, r_diff;
  logic             r_ge;
  logic [EW-1:0]    e_raw;
  logic             e_ovf, e_unf;
  logic [MAN_W-1:0] mant;

  assign a_zero  = (a[DW-2:0] == '0);
  assign b_zero  = (b[DW-2:0] == '0);
  assign in_sign = a[DW-1] ^ b[DW-1];

  assign sb_ext = {1'b0, sb_q};
  assign r_ge   = (r_q >= sb_ext);
  assign r_diff = r_q - sb_ext;

  // A quotient without its integer bit set is normalised one binade lower.
  assign e_raw = {2'b00, ea_q} - {2'b00, eb_q} + BIAS_E
               - {{(EW-1){1'b0}}, ~q_q[RW-1]};
  assign e_ovf = !e_raw[EW-1] && (e_raw[EW-2:0] >= EXP_MAX);
  assign e_unf = e_raw[EW-1] || (e_raw == '0);
  assign mant  = q_q[RW-1] ? q_q[RW-2:1] : q_q[RW-3:0];

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    q_d     = q_q;
    sb_d    = sb_q;
    cnt_d   = cnt_q;
    ea_d    = ea_q;
    eb_d    = eb_q;
    sign_d  = sign_q;
    quot_d  = quot_q;
    dbz_d   = dbz_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          sign_d = in_sign;
          ea_d   = a[DW-2:MAN_W];
          eb_d   = b[DW-2:MAN_W];
          if (a_zero && b_zero) begin
            quot_d  = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};
            dbz_d   = 1'b1;
            state_d = DONE;
          end else if (b_zero) begin
            quot_d  = {in_sign, EXP_ONES, {MAN_W{1'b0}}};
            dbz_d   = 1'b1;
            state_d = DONE;
          end else if (a_zero) begin
            quot_d  = {in_sign, {(DW-1){1'b0}}};
            dbz_d   = 1'b0;
            state_d = DONE;
          end else begin
            r_d     = {2'b01, a[MAN_W-1:0]};
            sb_d    = {1'b1, b[MAN_W-1:0]};
            q_d     = '0;
            cnt_d   = '0;
            state_d = DIV;
          end
        end
      end
      DIV: begin
        r_d = r_ge ? (r_diff << 1) : (r_q << 1);
        q_d = {q_q[RW-2:0], r_ge};
        if (cnt_q == CNT_LAST) begin
          state_d = NORM;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      NORM: begin
        dbz_d = 1'b0;
        if (e_ovf) begin
          quot_d = {sign_q, EXP_ONES, {MAN_W{1'b0}}};
        end else if (e_unf) begin
          quot_d = {sign_q, {(DW-1){1'b0}}};
        end else begin
          quot_d = {sign_q, e_raw[EXP_W-1:0], mant};
        end
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      r_q     <= '0;
      q_q     <= '0;
      sb_q    <= '0;
      cnt_q   <= '0;
      ea_q    <= '0;
      eb_q    <= '0;
      sign_q  <= 1'b0;
      quot_q  <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      q_q     <= q_d;
      sb_q    <= sb_d;
      cnt_q   <= cnt_d;
      ea_q    <= ea_d;
      eb_q    <= eb_d;
      sign_q  <= sign_d;
      quot_q  <= quot_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy        = (state_q != IDLE);
  assign valid       = (state_q == DONE);
  assign quotient    = quot_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_fp_divider.sv
// Directed-vector bench for fp_divider: results, latency, handshake,
// ignored start while busy and mid-operation reset.
module tb_fp_divider;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        valid;
  logic [31:0] quotient;
  logic        div_by_zero;

  int n_tests;
  int n_fail;
  int vcount;

  // Edges after the start-sampling edge until valid is visible.
  localparam int LAT_NORM = 26;
  localparam int LAT_SPEC = 0;

  fp_divider dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .valid       (valid),
    .quotient    (quotient),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (valid) vcount++;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run_op(input string tag, input logic [31:0] av,
                        input logic [31:0] bv, input logic [31:0] qe,
                        input logic de, input int late);
    int lat;
    int bcnt;
    a = av;
    b = bv;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    lat  = 0;
    bcnt = busy ? 1 : 0;
    while (!valid && lat < 100) begin
      tick(1);
      lat++;
      if (busy) bcnt++;
    end
    chk({tag, "_lat"}, 32'(lat), 32'(late));
    chk({tag, "_q"}, quotient, qe);
    chk({tag, "_dbz"}, {31'b0, div_by_zero}, {31'b0, de});
    chk({tag, "_busycyc"}, 32'(bcnt), 32'(late + 1));
    tick(1);
    chk({tag, "_vpulse"}, {31'b0, valid}, 32'd0);
    chk({tag, "_idle"}, {31'b0, busy}, 32'd0);
  endtask

  initial begin
    int vbase;
    n_tests = 0;
    n_fail  = 0;
    vcount  = 0;
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    tick(2);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_valid", {31'b0, valid}, 32'd0);
    chk("rst_q", quotient, 32'h0);
    chk("rst_dbz", {31'b0, div_by_zero}, 32'd0);
    rst = 1'b0;
    tick(1);

    run_op("6div2", 32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, LAT_NORM);
    run_op("1div3", 32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 1'b0, LAT_NORM);
    run_op("m8divh", 32'hC1000000, 32'h3F000000, 32'hC1800000, 1'b0, LAT_NORM);
    run_op("xdiv0", 32'h3F800000, 32'h00000000, 32'h7F800000, 1'b1, LAT_SPEC);
    run_op("0div0", 32'h00000000, 32'h00000000, 32'h7FC00000, 1'b1, LAT_SPEC);
    run_op("0divn", 32'h00000000, 32'hC0000000, 32'h80000000, 1'b0, LAT_SPEC);
    run_op("ovf", 32'h7F000000, 32'h00800000, 32'h7F800000, 1'b0, LAT_NORM);
    run_op("unf", 32'h00800000, 32'h7F000000, 32'h00000000, 1'b0, LAT_NORM);

    // start while busy must be dropped, not queued
    vbase = vcount;
    a = 32'h3F800000;
    b = 32'h40400000;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(4);
    a = 32'h40C00000;
    b = 32'h40000000;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(60);
    chk("ign_vcount", 32'(vcount - vbase), 32'd1);
    chk("ign_q", quotient, 32'h3EAAAAAA);
    chk("ign_idle", {31'b0, busy}, 32'd0);

    // reset during DIV aborts with no valid
    vbase = vcount;
    a = 32'hC1000000;
    b = 32'h3F000000;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(9);
    chk("abort_busy_pre", {31'b0, busy}, 32'd1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("abort_busy", {31'b0, busy}, 32'd0);
    chk("abort_valid", {31'b0, valid}, 32'd0);
    chk("abort_q", quotient, 32'h0);
    chk("abort_dbz", {31'b0, div_by_zero}, 32'd0);
    tick(40);
    chk("abort_novalid", 32'(vcount - vbase), 32'd0);

    run_op("post_rst", 32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, LAT_NORM);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
